// File: rtl/output_ram_writer.sv
// -----------------------------------------------------------------------------
// output_ram_writer
//
// Purpose:
//   Raster-order pixel sink. It accepts one processed 8-bit pixel on each
//   valid/ready handshake and writes it into the output frame RAM. Column and
//   row coordinates are generated internally. The RAM address is
//   (row << WIDTH_BITS) + col, which is the same mapping used on the input
//   side. After the last pixel of a frame is accepted, a one-cycle oDone pulse
//   tells the top-level controller that the frame is complete.
//
// Ports:
//   clock       system clock; all state changes on the rising edge
//   reset       asynchronous, active-high reset
//   iStart      single-cycle start-of-frame request (only honoured in IDLE)
//   iValid      pixel on iData is valid
//   iData       processed pixel value
//   oReady      block accepts a pixel this cycle (decoded from state)
//   oBusy       frame write in progress (decoded from state)
//   oDone       one-cycle pulse in the cycle after the last pixel is accepted
//   oCol        column of the next pixel to accept
//   oRow        row of the next pixel to accept
//   oWrAddress  RAM write address (registered)
//   oWrData     RAM write data (registered)
//   oWrEn       RAM write enable (registered)
// -----------------------------------------------------------------------------
module output_ram_writer #(
    parameter int WIDTH_BITS  = 7,
    parameter int HEIGHT_BITS = 7,
    parameter int ADDR_WIDTH  = 14
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iStart,
    input  logic                   iValid,
    input  logic [7:0]             iData,
    output logic                   oReady,
    output logic                   oBusy,
    output logic                   oDone,
    output logic [WIDTH_BITS-1:0]  oCol,
    output logic [HEIGHT_BITS-1:0] oRow,
    output logic [ADDR_WIDTH-1:0]  oWrAddress,
    output logic [7:0]             oWrData,
    output logic                   oWrEn
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH_BITS-1:0]  COL_MAX = {WIDTH_BITS{1'b1}};
    localparam logic [HEIGHT_BITS-1:0] ROW_MAX = {HEIGHT_BITS{1'b1}};

    state_t                  state_q, state_d;
    logic [WIDTH_BITS-1:0]   col_q,   col_d;
    logic [HEIGHT_BITS-1:0]  row_q,   row_d;
    logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
    logic [7:0]              data_q,  data_d;
    logic                    wren_q,  wren_d;

    logic handshake;

    // Ready is taken straight from the state, so a handshake only needs
    // iValid while the block is in WRITE.
    assign handshake = (state_q == ST_WRITE) && iValid;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wren_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d = ST_WRITE;
                    col_d   = '0;
                    row_d   = '0;
                end
            end

            ST_WRITE: begin
                if (handshake) begin
                    // The address is built at full RAM width, so no carry
                    // out of the column field can corrupt the row field.
                    addr_d = (ADDR_WIDTH'(row_q) << WIDTH_BITS) + ADDR_WIDTH'(col_q);
                    data_d = iData;
                    wren_d = 1'b1;
                    if (col_q == COL_MAX) begin
                        col_d = '0;
                        // The row wraps naturally after the last row, which
                        // leaves the counters at (0,0) for the next frame.
                        row_d = row_q + 1'b1;
                        if (row_q == ROW_MAX) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                // The write of the last pixel is still visible during this
                // cycle (wren_q). iStart is deliberately not looked at here.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
        end
    end

    assign oReady     = (state_q == ST_WRITE);
    assign oBusy      = (state_q == ST_WRITE) || (state_q == ST_DONE);
    assign oDone      = (state_q == ST_DONE);
    assign oCol       = col_q;
    assign oRow       = row_q;
    assign oWrAddress = addr_q;
    assign oWrData    = data_q;
    assign oWrEn      = wren_q;

endmodule

// File: tb/tb_output_ram_writer.sv
// -----------------------------------------------------------------------------
// tb_output_ram_writer
//
// Purpose:
//   Self-checking bench for output_ram_writer on a 4x4 image (WIDTH_BITS=2,
//   HEIGHT_BITS=2). A behavioural model tracks the frame as a count of
//   accepted pixels. Expected coordinates, addresses, busy/ready/done and the
//   pending RAM write are all derived from that count with plain arithmetic.
//   Directed sequences cover idle behaviour, a full frame, a row wrap, stalls,
//   a reset in the middle of a frame and ignored starts. A long randomized run
//   follows them.
// -----------------------------------------------------------------------------
module tb_output_ram_writer;

    localparam int WB = 2;
    localparam int HB = 2;
    localparam int AW = 4;
    localparam int IMG_W  = 1 << WB;
    localparam int IMG_H  = 1 << HB;
    localparam int NPIX   = IMG_W * IMG_H;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          iStart = 1'b0;
    logic          iValid = 1'b0;
    logic [7:0]    iData  = 8'h00;
    logic          oReady, oBusy, oDone, oWrEn;
    logic [WB-1:0] oCol;
    logic [HB-1:0] oRow;
    logic [AW-1:0] oWrAddress;
    logic [7:0]    oWrData;

    output_ram_writer #(
        .WIDTH_BITS (WB),
        .HEIGHT_BITS(HB),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iStart    (iStart),
        .iValid    (iValid),
        .iData     (iData),
        .oReady    (oReady),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oCol      (oCol),
        .oRow      (oRow),
        .oWrAddress(oWrAddress),
        .oWrData   (oWrData),
        .oWrEn     (oWrEn)
    );

    always #5 clock = ~clock;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model: a frame is "in progress" with m_count pixels accepted.
    bit m_active = 0;   // frame in progress, pixels accepted
    bit m_done   = 0;   // the cycle right after the final accept
    int m_count  = 0;   // pixels accepted in the current frame
    bit m_wren   = 0;
    int m_addr   = 0;
    int m_data   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        check_val("ready", 32'(oReady), 32'(m_active));
        check_val("busy",  32'(oBusy),  32'(m_active || m_done));
        check_val("done",  32'(oDone),  32'(m_done));
        check_val("col",   32'(oCol),   32'(m_count % IMG_W));
        check_val("row",   32'(oRow),   32'((m_count / IMG_W) % IMG_H));
        check_val("wren",  32'(oWrEn),  32'(m_wren));
        check_val("addr",  32'(oWrAddress), 32'(m_addr));
        check_val("data",  32'(oWrData),    32'(m_data));
    endtask

    // One clock: check what the previous edge produced, apply new inputs,
    // then advance the model to what the coming edge should produce.
    task automatic step(input logic st, input logic v, input logic [7:0] d);
        @(negedge clock);
        compare_outputs();
        $display("step start=%0d valid=%0d data=%02h | wren=%0d addr=%0d wdata=%02h col=%0d row=%0d done=%0d",
                 st, v, d, oWrEn, oWrAddress, oWrData, oCol, oRow, oDone);
        iStart = st;
        iValid = v;
        iData  = d;
        if (m_done) begin
            m_done = 0;
            m_wren = 0;
        end else if (m_active) begin
            if (v) begin
                m_wren  = 1;
                m_addr  = m_count;
                m_data  = int'(d);
                m_count = m_count + 1;
                if (m_count == NPIX) begin
                    m_count  = 0;
                    m_active = 0;
                    m_done   = 1;
                end
            end else begin
                m_wren = 0;
            end
        end else begin
            m_wren = 0;
            if (st) begin
                m_active = 1;
                m_count  = 0;
            end
        end
    endtask

    // Assert reset between edges; the outputs must drop without a clock.
    task automatic do_reset();
        @(negedge clock);
        iStart = 1'b0;
        iValid = 1'b0;
        reset  = 1'b1;
        #1;
        check_val("rst_wren",  32'(oWrEn),  32'd0);
        check_val("rst_busy",  32'(oBusy),  32'd0);
        check_val("rst_ready", 32'(oReady), 32'd0);
        check_val("rst_done",  32'(oDone),  32'd0);
        m_active = 0;
        m_done   = 0;
        m_count  = 0;
        m_wren   = 0;
        m_addr   = 0;
        m_data   = 0;
        @(negedge clock);
        reset = 1'b0;
        $display("reset applied");
    endtask

    initial begin
        // Reset, then sit idle with valid data that must be ignored.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'hAA);

        // Full frame, back-to-back pixels 0x10..0x1F.
        step(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < NPIX; k++) step(1'b0, 1'b1, 8'(8'h10 + k));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);

        // Row wrap: five accepts leave the counters at col 1, row 1.
        step(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 8'(8'h40 + k));
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Stall pattern 1,0,0,1 from a fresh frame, then reset after 7 accepts.
        do_reset();
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h60);
        step(1'b0, 1'b0, 8'h61);
        step(1'b0, 1'b0, 8'h62);
        step(1'b0, 1'b1, 8'h63);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 8'(8'h70 + k));
        step(1'b0, 1'b0, 8'h00);
        do_reset();

        // Restart from address 0 with starts during WRITE and during DONE.
        step(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < NPIX; k++) step(k == 5 || k == 11, 1'b1, 8'(8'h80 + k));
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);

        // Randomized traffic: sporadic starts, about 75% valid.
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 8) == 0, ($urandom % 4) != 0, 8'($urandom));
        end
        step(1'b0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
